// File: rtl/reg_file_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_pkg
// Shared constants for the multi-port register file and the hazard unit.
//   INIT_INDEX / INIT_ZERO : reset-content modes (register i resets to i / 0)
//   DEF_DATA_W / DEF_ADDR_W / DEF_NUM_REGS : default geometry shared by the
//   register file and the hazard unit so both agree on register numbering.
// ---------------------------------------------------------------------------
package reg_file_pkg;

    localparam int INIT_ZERO    = 0;
    localparam int INIT_INDEX   = 1;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 4;
    localparam int DEF_NUM_REGS = 15;

endpackage : reg_file_pkg

// File: rtl/reg_file_mp_pend_cnt.sv
// ---------------------------------------------------------------------------
// reg_pend_cnt
// Saturating pending-write counter for one register.
//   clk, rst      : clock, synchronous active-high reset (clears the count)
//   inc           : a reservation targets this register this cycle
//   dec[1:0]      : number of writes (0..2) landing on this register now
//   busy_now      : stored count is non-zero
//   busy_after_wr : count after this cycle's writes (floored at 0) is non-zero
//   sat_hit       : a reservation arrived while the post-write count is at max
// ---------------------------------------------------------------------------
module reg_pend_cnt
    import reg_file_pkg::*;
#(
    parameter int PEND_W = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic [1:0] dec,
    output logic       busy_now,
    output logic       busy_after_wr,
    output logic       sat_hit
);

    localparam logic [PEND_W-1:0] CNT_MAX = '1;

    logic [PEND_W-1:0] cnt_q;
    logic [PEND_W-1:0] cnt_d;
    logic [PEND_W-1:0] after_dec;
    logic [PEND_W+1:0] cnt_ext;
    logic [PEND_W+1:0] dec_ext;

    always_comb begin
        cnt_ext = {2'b00, cnt_q};
        dec_ext = {{PEND_W{1'b0}}, dec};
        // Writes with no matching reservation (e.g. debug pokes) must not
        // wrap the count below zero.
        if (cnt_ext > dec_ext) begin
            after_dec = PEND_W'(cnt_ext - dec_ext);
        end else begin
            after_dec = '0;
        end
        sat_hit = inc && (after_dec == CNT_MAX);
        if (sat_hit) begin
            cnt_d = CNT_MAX;
        end else begin
            cnt_d = after_dec + PEND_W'(inc);
        end
        busy_now      = (cnt_q != '0);
        busy_after_wr = (after_dec != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : reg_pend_cnt

// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp
// Multi-port register file with two write ports, optional same-cycle
// write-to-read bypass and per-register pending-write counters.
//   clk, rst           : clock, synchronous active-high reset
//   rd_addr / rd_data  : NUM_RD packed read ports, combinational read
//   rd_busy            : per read port, addressed register has an outstanding write
//   wr0_* / wr1_*      : write ports; wr1 wins when both hit the same register
//   rsv_en / rsv_addr  : reservation of a destination register at issue
//   ovf_err            : sticky, a reservation hit a saturated counter
// Addresses >= NUM_REGS are inert: writes/reservations ignored, reads give 0.
// ---------------------------------------------------------------------------
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int NUM_REGS  = DEF_NUM_REGS,
    parameter int NUM_RD    = 3,
    parameter int BYPASS    = 1,
    parameter int INIT_MODE = INIT_INDEX,
    parameter int PEND_W    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr0_en,
    input  logic [ADDR_W-1:0]          wr0_addr,
    input  logic [DATA_W-1:0]          wr0_data,
    input  logic                       wr1_en,
    input  logic [ADDR_W-1:0]          wr1_addr,
    input  logic [DATA_W-1:0]          wr1_data,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    output logic                       ovf_err
);

    // One extra bit so NUM_REGS == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W+1)'(NUM_REGS);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              ovf_err_q;
    logic              ovf_err_d;

    logic              wr0_ok;
    logic              wr1_ok;
    logic              rsv_ok;

    logic [NUM_REGS-1:0] busy_now;
    logic [NUM_REGS-1:0] busy_after_wr;
    logic [NUM_REGS-1:0] sat_hit;

    function automatic logic [DATA_W-1:0] init_val(input int idx);
        if (INIT_MODE == INIT_INDEX) begin
            return DATA_W'(idx);
        end
        return '0;
    endfunction

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < NUM_REGS_L);
    endfunction

    assign wr0_ok = wr0_en && in_range(wr0_addr);
    assign wr1_ok = wr1_en && in_range(wr1_addr);
    assign rsv_ok = rsv_en && in_range(rsv_addr);

    // -----------------------------------------------------------------------
    // Register array: wr1 applied after wr0 so it wins on an address clash.
    // -----------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr0_ok) begin
            regs_d[wr0_addr] = wr0_data;
        end
        if (wr1_ok) begin
            regs_d[wr1_addr] = wr1_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= init_val(i);
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Pending-write counters, one per implemented register.
    // -----------------------------------------------------------------------
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_pend
        logic       hit0;
        logic       hit1;
        logic       hit_rsv;
        logic [1:0] dec;

        assign hit0    = wr0_ok && (wr0_addr == ADDR_W'(r));
        assign hit1    = wr1_ok && (wr1_addr == ADDR_W'(r));
        assign hit_rsv = rsv_ok && (rsv_addr == ADDR_W'(r));
        assign dec     = {1'b0, hit0} + {1'b0, hit1};

        reg_pend_cnt #(
            .PEND_W (PEND_W)
        ) u_cnt (
            .clk           (clk),
            .rst           (rst),
            .inc           (hit_rsv),
            .dec           (dec),
            .busy_now      (busy_now[r]),
            .busy_after_wr (busy_after_wr[r]),
            .sat_hit       (sat_hit[r])
        );
    end

    assign ovf_err_d = ovf_err_q || (|sat_hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_err_q <= 1'b0;
        end else begin
            ovf_err_q <= ovf_err_d;
        end
    end

    assign ovf_err = ovf_err_q;

    // -----------------------------------------------------------------------
    // Read ports: stored value, optionally overridden by a write landing this
    // cycle (wr1 checked first). Busy follows the same bypass choice so a
    // consumer never sees "not busy" paired with stale data.
    // -----------------------------------------------------------------------
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            logic [ADDR_W-1:0] a;
            a = rd_addr[k*ADDR_W +: ADDR_W];
            if (in_range(a)) begin
                rd_data[k*DATA_W +: DATA_W] = regs_q[a];
                if (BYPASS != 0) begin
                    if (wr1_ok && (wr1_addr == a)) begin
                        rd_data[k*DATA_W +: DATA_W] = wr1_data;
                    end else if (wr0_ok && (wr0_addr == a)) begin
                        rd_data[k*DATA_W +: DATA_W] = wr0_data;
                    end
                    rd_busy[k] = busy_after_wr[a];
                end else begin
                    rd_busy[k] = busy_now[a];
                end
            end
        end
    end

endmodule : reg_file_mp

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] rd_addr;
    logic [95:0] rd_data_b, rd_data_n;
    logic [2:0]  busy_b, busy_n;
    logic        wr0_en, wr1_en, rsv_en;
    logic [3:0]  wr0_addr, wr1_addr, rsv_addr;
    logic [31:0] wr0_data, wr1_data;
    logic        ovf_b, ovf_n;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    reg_file_mp #(.BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(busy_b),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .ovf_err(ovf_b)
    );

    reg_file_mp #(.BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(busy_n),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .ovf_err(ovf_n)
    );

    task automatic idle();
        wr0_en = 0; wr1_en = 0; rsv_en = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1; wr0_en = 1; wr0_addr = 4'd3; wr0_data = 32'hAA;
        rd_addr = {4'd14, 4'd7, 4'd0};
        @(negedge clk);
        rst = 0; idle();
        #1;
        tests++;
        if (rd_data_b !== {32'd14, 32'd7, 32'd0}) begin
            fails++; $display("FAIL reset_data got %h want %h", rd_data_b, {32'd14, 32'd7, 32'd0});
        end
        tests++;
        if (busy_b !== 3'b000 || busy_n !== 3'b000) begin
            fails++; $display("FAIL reset_busy got %b/%b want 000", busy_b, busy_n);
        end
        tests++;
        if (ovf_b !== 1'b0) begin
            fails++; $display("FAIL reset_ovf got %b want 0", ovf_b);
        end
        rd_addr[3:0] = 4'd3;
        #1;
        tests++;
        if (rd_data_b[31:0] !== 32'd3) begin
            fails++; $display("FAIL reset_over_write got %h want 3", rd_data_b[31:0]);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        rd_addr = {4'd14, 4'd7, 4'd5};
        wr0_en = 1; wr0_addr = 4'd5; wr0_data = 32'h1234;
        #1;
        tests++;
        if (rd_data_b[31:0] !== 32'h1234) begin
            fails++; $display("FAIL bypass_on got %h want 1234", rd_data_b[31:0]);
        end
        tests++;
        if (rd_data_n[31:0] !== 32'd5) begin
            fails++; $display("FAIL bypass_off got %h want 5", rd_data_n[31:0]);
        end
        @(negedge clk);
        idle();
        #1;
        tests++;
        if (rd_data_b[31:0] !== 32'h1234 || rd_data_n[31:0] !== 32'h1234) begin
            fails++; $display("FAIL write_stored got %h/%h want 1234", rd_data_b[31:0], rd_data_n[31:0]);
        end
    endtask

    task automatic test_dual_write();
        @(negedge clk);
        rd_addr = {4'd14, 4'd2, 4'd5};
        rsv_en = 1; rsv_addr = 4'd2;
        @(negedge clk);
        @(negedge clk);
        idle();
        #1;
        tests++;
        if (busy_b[1] !== 1'b1 || busy_n[1] !== 1'b1) begin
            fails++; $display("FAIL dual_pre_busy got %b/%b want 1", busy_b[1], busy_n[1]);
        end
        wr0_en = 1; wr0_addr = 4'd2; wr0_data = 32'h11;
        wr1_en = 1; wr1_addr = 4'd2; wr1_data = 32'h22;
        #1;
        tests++;
        if (rd_data_b[63:32] !== 32'h22) begin
            fails++; $display("FAIL dual_bypass got %h want 22", rd_data_b[63:32]);
        end
        tests++;
        if (busy_b[1] !== 1'b0 || busy_n[1] !== 1'b1) begin
            fails++; $display("FAIL dual_busy_now got %b/%b want 0/1", busy_b[1], busy_n[1]);
        end
        @(negedge clk);
        idle();
        #1;
        tests++;
        if (rd_data_b[63:32] !== 32'h22 || rd_data_n[63:32] !== 32'h22) begin
            fails++; $display("FAIL dual_stored got %h/%h want 22", rd_data_b[63:32], rd_data_n[63:32]);
        end
        tests++;
        if (busy_b[1] !== 1'b0 || busy_n[1] !== 1'b0) begin
            fails++; $display("FAIL dual_cnt_clear got %b/%b want 0", busy_b[1], busy_n[1]);
        end
    endtask

    task automatic test_reserve();
        @(negedge clk);
        rd_addr = {4'd4, 4'd2, 4'd5};
        rsv_en = 1; rsv_addr = 4'd4;
        #1;
        tests++;
        if (busy_b[2] !== 1'b0) begin
            fails++; $display("FAIL rsv_same_cycle got %b want 0", busy_b[2]);
        end
        @(negedge clk);
        @(negedge clk);
        idle();
        wr0_en = 1; wr0_addr = 4'd4; wr0_data = 32'h44;
        #1;
        tests++;
        if (busy_b[2] !== 1'b1 || busy_n[2] !== 1'b1) begin
            fails++; $display("FAIL rsv_first_wr got %b/%b want 1/1", busy_b[2], busy_n[2]);
        end
        @(negedge clk);
        idle();
        #1;
        tests++;
        if (busy_b[2] !== 1'b1 || rd_data_b[95:64] !== 32'h44) begin
            fails++; $display("FAIL rsv_after_first got %b/%h want 1/44", busy_b[2], rd_data_b[95:64]);
        end
        wr1_en = 1; wr1_addr = 4'd4; wr1_data = 32'h45;
        #1;
        tests++;
        if (busy_b[2] !== 1'b0 || busy_n[2] !== 1'b1) begin
            fails++; $display("FAIL rsv_second_wr got %b/%b want 0/1", busy_b[2], busy_n[2]);
        end
        @(negedge clk);
        idle();
        #1;
        tests++;
        if (busy_b[2] !== 1'b0 || busy_n[2] !== 1'b0) begin
            fails++; $display("FAIL rsv_drained got %b/%b want 0/0", busy_b[2], busy_n[2]);
        end
        rsv_en = 1; rsv_addr = 4'd4;
        @(negedge clk);
        wr0_en = 1; wr0_addr = 4'd4; wr0_data = 32'h46;
        #1;
        tests++;
        if (busy_b[2] !== 1'b0 || busy_n[2] !== 1'b1) begin
            fails++; $display("FAIL rsv_and_wr_now got %b/%b want 0/1", busy_b[2], busy_n[2]);
        end
        @(negedge clk);
        idle();
        #1;
        tests++;
        if (busy_b[2] !== 1'b1 || busy_n[2] !== 1'b1) begin
            fails++; $display("FAIL rsv_and_wr_net got %b/%b want 1/1", busy_b[2], busy_n[2]);
        end
        wr0_en = 1; wr0_addr = 4'd4; wr0_data = 32'h47;
        @(negedge clk);
        idle();
        #1;
        tests++;
        if (busy_b[2] !== 1'b0 || rd_data_b[95:64] !== 32'h47) begin
            fails++; $display("FAIL rsv_final got %b/%h want 0/47", busy_b[2], rd_data_b[95:64]);
        end
    endtask

    task automatic test_overflow();
        @(negedge clk);
        rd_addr = {4'd4, 4'd2, 4'd1};
        rsv_en = 1; rsv_addr = 4'd1;
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if (ovf_b !== 1'b0 || busy_b[0] !== 1'b1) begin
            fails++; $display("FAIL ovf_at_max got %b/%b want 0/1", ovf_b, busy_b[0]);
        end
        @(negedge clk);
        idle();
        #1;
        tests++;
        if (ovf_b !== 1'b1 || ovf_n !== 1'b1 || busy_b[0] !== 1'b1) begin
            fails++; $display("FAIL ovf_set got %b/%b busy %b want 1/1 busy 1", ovf_b, ovf_n, busy_b[0]);
        end
        wr0_en = 1; wr0_addr = 4'd1; wr0_data = 32'h10;
        repeat (2) @(negedge clk);
        idle();
        #1;
        tests++;
        if (busy_b[0] !== 1'b1) begin
            fails++; $display("FAIL ovf_held_at_3 got %b want 1", busy_b[0]);
        end
        wr0_en = 1; wr0_addr = 4'd1; wr0_data = 32'h10;
        @(negedge clk);
        idle();
        #1;
        tests++;
        if (busy_b[0] !== 1'b0 || ovf_b !== 1'b1) begin
            fails++; $display("FAIL ovf_sticky got busy %b ovf %b want 0/1", busy_b[0], ovf_b);
        end
        rst = 1;
        @(negedge clk);
        rst = 0;
        #1;
        tests++;
        if (ovf_b !== 1'b0 || ovf_n !== 1'b0 || rd_data_b[31:0] !== 32'd1) begin
            fails++; $display("FAIL ovf_rst got %b/%b data %h want 0/0 data 1", ovf_b, ovf_n, rd_data_b[31:0]);
        end
    endtask

    task automatic test_out_of_range();
        @(negedge clk);
        rd_addr = {4'd15, 4'd15, 4'd15};
        wr0_en = 1; wr0_addr = 4'd15; wr0_data = 32'hFFFF;
        wr1_en = 1; wr1_addr = 4'd15; wr1_data = 32'hEEEE;
        rsv_en = 1; rsv_addr = 4'd15;
        #1;
        tests++;
        if (rd_data_b !== 96'd0 || busy_b !== 3'b000) begin
            fails++; $display("FAIL oor_read got %h busy %b want 0/000", rd_data_b, busy_b);
        end
        repeat (4) @(negedge clk);
        idle();
        #1;
        tests++;
        if (rd_data_b !== 96'd0 || ovf_b !== 1'b0 || busy_n !== 3'b000) begin
            fails++; $display("FAIL oor_after got %h ovf %b busy %b want 0/0/000", rd_data_b, ovf_b, busy_n);
        end
        for (int i = 0; i < 15; i++) begin
            rd_addr = {4'd15, 4'd15, 4'(i)};
            #1;
            tests++;
            if (rd_data_b[31:0] !== 32'(i) || busy_b[0] !== 1'b0 || busy_n[0] !== 1'b0) begin
                fails++; $display("FAIL oor_reg%0d got %h busy %b want %h busy 0", i, rd_data_b[31:0], busy_b[0], i);
            end
        end
    endtask

    initial begin
        rst = 1; rd_addr = '0; idle();
        wr0_addr = '0; wr1_addr = '0; rsv_addr = '0; wr0_data = '0; wr1_data = '0;
        test_reset();
        test_bypass();
        test_dual_write();
        test_reserve();
        test_overflow();
        test_out_of_range();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_reg_file_mp

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port register file that succeeds the single-write, two-read processor register file.
- Adds:
  - N read ports.
  - Two write ports: writeback and base-writeback.
  - Same-cycle write-to-read bypass.
  - Per-register pending-write counters, so the hazard unit can stall on outstanding writes.
- Sits between the ID stage (reads, reservations) and the WB stage (writes).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 4, register address width.
- NUM_REGS, 15, implemented registers (0..NUM_REGS-1), NUM_REGS <= 2**ADDR_W.
- NUM_RD, 3, number of read ports.
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see stored value only.
- INIT_MODE, 1, 1 = register i resets to i; 0 = all registers reset to 0.
- PEND_W, 2, width of each pending-write counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k = bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data, combinational.
- rd_busy  out  NUM_RD  per read port: addressed register has an outstanding write.
- wr0_en  in  1  write port 0 enable.
- wr0_addr  in  ADDR_W  write port 0 address.
- wr0_data  in  DATA_W  write port 0 data.
- wr1_en  in  1  write port 1 enable; higher priority than port 0.
- wr1_addr  in  ADDR_W  write port 1 address.
- wr1_data  in  DATA_W  write port 1 data.
- rsv_en  in  1  reserve a register (destination of an issuing instruction).
- rsv_addr  in  ADDR_W  register to reserve.
- ovf_err  out  1  sticky flag: a reservation hit a saturated counter.

Behaviour:
- Reset (rst=1 at rising edge):
  - Registers load i (INIT_MODE=1) or 0.
  - All counters clear to 0 and ovf_err clears to 0.
  - Reset overrides any write or reservation in the same cycle.
  - Outputs after reset: rd_data = init contents, rd_busy = 0, ovf_err = 0.
- Writes:
  - Take effect at the rising edge; data is visible on rd_data the following cycle.
  - Both ports writing the same address: wr1_data is stored.
- Out-of-range addresses (>= NUM_REGS):
  - Writes and reservations are ignored; counters are unchanged.
  - Reads return 0 with rd_busy = 0.
- Read latency: zero (combinational from rd_addr and state).
- Bypass (BYPASS=1): if rd_addr[k] matches an enabled in-range write address this cycle, rd_data[k] = that write's data (wr1 before wr0). BYPASS=0: stored value only.
- Pending counter per register, cnt[r], updated every edge (rst=0):
  - dec = (wr0_en && wr0_addr==r) + (wr1_en && wr1_addr==r), value 0..2.
  - inc = rsv_en && rsv_addr==r.
  - next = cnt - dec + inc, clamped below at 0 (writes without reservation allowed, e.g. debug).
  - If cnt - dec (floored at 0) == 2**PEND_W-1 and inc=1: the counter holds at the maximum and ovf_err sets.
  - Simultaneous reservation and write to the same register: net effect applied, so cnt=1, dec=1, inc=1 gives 1.
- rd_busy[k]:
  - BYPASS=1: (cnt[r] minus this-cycle dec, floored at 0) != 0, so a write landing now clears busy combinationally.
  - BYPASS=0: cnt[r] != 0.
  - The same-cycle reservation never affects rd_busy.
- ovf_err: sticky until rst.
- No other state machine; the block is a pure register array plus counters.

Decomposition:
- Package reg_file_pkg holds:
  - INIT_INDEX / INIT_ZERO mode constants.
  - The default DATA_W/ADDR_W/NUM_REGS localparams shared with the hazard unit.
- Sub-module reg_pend_cnt: one saturating up/down counter (PEND_W).
  - Inputs: inc, dec[1:0].
  - Outputs: busy_now (cnt!=0), busy_after_wr (cnt-dec != 0), sat_hit.
  - Instantiated NUM_REGS times via generate.

Test Plan:
- Reset with INIT_MODE=1, rd_addr = {0,7,14} -> rd_data = {0,7,14}, rd_busy = 0, ovf_err = 0. rst during an active wr0 to r3 (data 0xAA) -> r3 reads 3 afterwards.
- wr0 r5 = 0x1234 while port 0 reads r5 with BYPASS=1 -> same cycle shows 0x1234. With BYPASS=0 -> shows 5, then 0x1234 next cycle.
- wr0 r2 = 0x11 and wr1 r2 = 0x22 in the same cycle -> r2 reads 0x22 afterwards. Counter of r2 at 2 drops to 0.
- Reserve r4 twice -> rd_busy=1 for r4. Write r4 once -> still busy. Second write -> rd_busy deasserts in the write cycle (BYPASS=1). Reserve and write r4 in the same cycle from cnt=1 -> stays busy.
- PEND_W=2: reserve r1 four times with no writes -> counter stays at 3, ovf_err=1 and remains 1 after subsequent writes, until rst.
- Write/reserve/read address 15 (NUM_REGS=15) -> no state change, rd_data = 0, rd_busy = 0.
